uart_rx_frame_ctrl: RTL
=======================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameters SHALL be one per line:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes.
- DEFAULT_CLKS_PER_BIT, 16'd87, reset value of o_Clks_Per_Bit.
REQ-002 Ports SHALL be one per line:
- i_Clock  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle byte strobe from the UART receiver.
- i_Rx_Byte  in  8  received byte, valid with i_Rx_DV.
- i_Timeout_Clks  in  16  inter-byte timeout in clocks; 0 disables the timeout.
- i_Rd_Addr  in  4  payload buffer read index.
- i_Frm_Ack  in  1  reader releases the held frame.
- o_Rd_Data  out  8  buffer[i_Rd_Addr], combinational read.
- o_Frm_Rdy  out  1  a checked frame is held.
- o_Frm_Len  out  5  payload length of the held frame.
- o_Frm_Cnt  out  8  count of accepted frames, wraps.
- o_Err_Len, o_Err_Chk, o_Err_Tmo, o_Drop  out  1 each  one-cycle error pulses.
- o_Clks_Per_Bit  out  16  baud divisor driven to the UART receiver.

Function
REQ-003 Frame format SHALL be SOF_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-004 The FSM SHALL have states S_IDLE, S_LEN, S_DATA, S_CHK, S_HOLD and advance only on i_Rx_DV, except for timeout and ack.
REQ-005 S_IDLE: i_Rx_DV with byte==SOF_BYTE -> S_LEN; any other byte is ignored silently.
REQ-006 S_LEN handling:
- LEN in 1..MAX_LEN: store LEN, seed the checksum with LEN, clear the index, go to S_DATA.
- Otherwise: pulse o_Err_Len, go to S_IDLE.
REQ-007 S_DATA: each byte is written to buffer[index], XORed into the checksum and the index incremented; after byte LEN -> S_CHK.
REQ-008 S_CHK: CHK equal to the checksum -> S_HOLD; the same edge sets o_Frm_Rdy and increments o_Frm_Cnt (wraps 255->0). A mismatch pulses o_Err_Chk -> S_IDLE.
REQ-009 S_HOLD: buffer and o_Frm_Len are frozen.
- i_Rx_DV without i_Frm_Ack: the byte is discarded and o_Drop pulses.
- i_Frm_Ack: clears o_Frm_Rdy and goes to S_IDLE next cycle.
REQ-010 i_Frm_Ack and i_Rx_DV in the same S_HOLD cycle: the byte is processed as an S_IDLE byte, so SOF -> S_LEN; o_Drop SHALL NOT pulse.
REQ-011 i_Frm_Ack outside S_HOLD SHALL be ignored.
REQ-012 Timeout counter:
- Clears on every i_Rx_DV and in S_IDLE/S_HOLD.
- Increments in S_LEN/S_DATA/S_CHK.
- When nonzero i_Timeout_Clks is reached with no i_Rx_DV: pulse o_Err_Tmo, go to S_IDLE.
- A byte arriving on the timeout cycle wins; no timeout is taken.
REQ-013 o_Frm_Rdy SHALL be asserted exactly in S_HOLD.
REQ-014 Latency SHALL be one clock from the CHK i_Rx_DV to o_Frm_Rdy high.

Reset
REQ-015 rst_i SHALL be sampled on the rising edge of i_Clock and override all activity, including mid-frame and in S_HOLD.
REQ-016 Reset values:
- State S_IDLE.
- o_Frm_Rdy, all pulse outputs, o_Frm_Len, o_Frm_Cnt, index, checksum and timeout counter all 0.
- o_Clks_Per_Bit = DEFAULT_CLKS_PER_BIT.
- Buffer contents are not reset.

Configuration
REQ-017 With macro UART_RX_FRAME_CMD_EN defined, a checked frame with LEN==3 and payload[0]==8'hC0 SHALL load o_Clks_Per_Bit={payload[1],payload[2]}.
- Such a frame goes to S_IDLE, not S_HOLD; o_Frm_Cnt still increments.
- Divisor value 0 is rejected with an o_Err_Len pulse.
REQ-018 Without UART_RX_FRAME_CMD_EN, o_Clks_Per_Bit SHALL be constant DEFAULT_CLKS_PER_BIT and every checked frame SHALL go to S_HOLD.

Structure
REQ-019 Package uart_frame_pkg SHALL hold the state encodings, the default SOF value, the C0 config opcode and the MAX_LEN default.
REQ-020 Sub-module uart_frame_buf SHALL be a MAX_LEN x 8 register file with one synchronous write port and one combinational read port.

Verification
REQ-021 Bench scenarios:
- Bytes A5 03 11 22 33 03 -> o_Frm_Rdy, o_Frm_Len=3, reads 11/22/33, o_Frm_Cnt=1; ack -> o_Frm_Rdy=0.
- A5 02 10 20 00 (bad CHK, expected 32) -> one o_Err_Chk pulse, o_Frm_Rdy stays 0.
- A5 00 and A5 11 -> one o_Err_Len pulse each, FSM back to S_IDLE.
- i_Timeout_Clks=50; A5 04 01 then silence -> o_Err_Tmo exactly 50 clocks after the last byte.
- In S_HOLD send 5A -> o_Drop; send A5 together with i_Frm_Ack -> no o_Drop, next frame is parsed.
- CMD_EN build: A5 03 C0 00 2B E8 -> o_Clks_Per_Bit=43, o_Frm_Rdy stays 0; rst_i mid-frame -> o_Clks_Per_Bit=87, all outputs at reset values.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared encodings and defaults for the UART receive frame controller.
// Optional command decoding is enabled by defining UART_RX_FRAME_CMD_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_HOLD = 3'd4
    } frame_state_t;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam logic [7:0] CFG_OPCODE      = 8'hC0;
    localparam int         MAX_LEN_DEFAULT = 16;

    // Running XOR checksum over LEN and payload bytes.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser for SOF/LEN/payload/CHK packets arriving from a UART receiver.
// Define UART_RX_FRAME_CMD_EN to let C0 command frames reload the baud divisor.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE             = SOF_DEFAULT,
    parameter int          MAX_LEN              = MAX_LEN_DEFAULT,
    parameter logic [15:0] DEFAULT_CLKS_PER_BIT = 16'd87
) (
    input  logic        i_Clock,
    input  logic        rst_i,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic [15:0] i_Timeout_Clks,
    input  logic [3:0]  i_Rd_Addr,
    input  logic        i_Frm_Ack,
    output logic [7:0]  o_Rd_Data,
    output logic        o_Frm_Rdy,
    output logic [4:0]  o_Frm_Len,
    output logic [7:0]  o_Frm_Cnt,
    output logic        o_Err_Len,
    output logic        o_Err_Chk,
    output logic        o_Err_Tmo,
    output logic        o_Drop,
    output logic [15:0] o_Clks_Per_Bit
);

    frame_state_t state_r;
    logic [4:0]   idx_r;
    logic [7:0]   chk_r;
    logic [15:0]  tmo_cnt_r;
    logic         tmo_hit_s;
    logic         len_ok_s;
    logic         buf_we_s;
`ifdef UART_RX_FRAME_CMD_EN
    logic [7:0]   cmd_op_r;
    logic [7:0]   cmd_hi_r;
    logic [7:0]   cmd_lo_r;
`endif

    assign tmo_hit_s = (i_Timeout_Clks != 16'd0) && (tmo_cnt_r == i_Timeout_Clks - 16'd1);
    assign len_ok_s  = (i_Rx_Byte != 8'd0) && (i_Rx_Byte <= 8'(MAX_LEN));
    assign buf_we_s  = (state_r == S_DATA) && i_Rx_DV;

    uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
        .clk   (i_Clock),
        .we    (buf_we_s),
        .waddr (idx_r[3:0]),
        .wdata (i_Rx_Byte),
        .raddr (i_Rd_Addr),
        .rdata (o_Rd_Data)
    );

    // Frame FSM with registered status, counters and error pulses.
    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            state_r        <= S_IDLE;
            idx_r          <= 5'd0;
            chk_r          <= 8'd0;
            tmo_cnt_r      <= 16'd0;
            o_Frm_Rdy      <= 1'b0;
            o_Frm_Len      <= 5'd0;
            o_Frm_Cnt      <= 8'd0;
            o_Err_Len      <= 1'b0;
            o_Err_Chk      <= 1'b0;
            o_Err_Tmo      <= 1'b0;
            o_Drop         <= 1'b0;
            o_Clks_Per_Bit <= DEFAULT_CLKS_PER_BIT;
`ifdef UART_RX_FRAME_CMD_EN
            cmd_op_r       <= 8'd0;
            cmd_hi_r       <= 8'd0;
            cmd_lo_r       <= 8'd0;
`endif
        end else begin
            o_Err_Len <= 1'b0;
            o_Err_Chk <= 1'b0;
            o_Err_Tmo <= 1'b0;
            o_Drop    <= 1'b0;
            if (i_Rx_DV || state_r == S_IDLE || state_r == S_HOLD) begin
                tmo_cnt_r <= 16'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
            case (state_r)
                S_IDLE: begin
                    if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) begin
                        state_r <= S_LEN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        if (len_ok_s) begin
                            o_Frm_Len <= i_Rx_Byte[4:0];
                            chk_r     <= i_Rx_Byte;
                            idx_r     <= 5'd0;
                            state_r   <= S_DATA;
                        end else begin
                            o_Err_Len <= 1'b1;
                            state_r   <= S_IDLE;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Tmo <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_LEN;
                    end
                end
                S_DATA: begin
                    if (i_Rx_DV) begin
                        chk_r <= chk_update(chk_r, i_Rx_Byte);
                        idx_r <= idx_r + 5'd1;
`ifdef UART_RX_FRAME_CMD_EN
                        if (idx_r == 5'd0) cmd_op_r <= i_Rx_Byte;
                        else if (idx_r == 5'd1) cmd_hi_r <= i_Rx_Byte;
                        else if (idx_r == 5'd2) cmd_lo_r <= i_Rx_Byte;
                        else cmd_op_r <= cmd_op_r;
`endif
                        if (idx_r + 5'd1 == o_Frm_Len) begin
                            state_r <= S_CHK;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Tmo <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_CHK: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == chk_r) begin
                            o_Frm_Cnt <= o_Frm_Cnt + 8'd1;
`ifdef UART_RX_FRAME_CMD_EN
                            // Command frames are consumed here and never presented to the reader.
                            if (o_Frm_Len == 5'd3 && cmd_op_r == CFG_OPCODE) begin
                                if ({cmd_hi_r, cmd_lo_r} != 16'd0) begin
                                    o_Clks_Per_Bit <= {cmd_hi_r, cmd_lo_r};
                                end else begin
                                    o_Err_Len <= 1'b1;
                                end
                                state_r <= S_IDLE;
                            end else begin
                                o_Frm_Rdy <= 1'b1;
                                state_r   <= S_HOLD;
                            end
`else
                            o_Frm_Rdy <= 1'b1;
                            state_r   <= S_HOLD;
`endif
                        end else begin
                            o_Err_Chk <= 1'b1;
                            state_r   <= S_IDLE;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Tmo <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_CHK;
                    end
                end
                S_HOLD: begin
                    if (i_Frm_Ack) begin
                        // A byte arriving with the ack is treated as the first idle byte.
                        o_Frm_Rdy <= 1'b0;
                        if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) begin
                            state_r <= S_LEN;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        o_Drop  <= i_Rx_DV;
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    o_Frm_Rdy <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
